msx_slot_mapper: RTL and testbench
==================================

// Module: msx_slot_mapper
// PURPOSE
//  Parametrised slot/memory-mapping unit for the MSX core, successor to the fixed
//  four-slot primary decoder. Adds per-primary-slot sub-slot expanders (register at
//  FFFFh, read back inverted) and an MSX2-style RAM mapper (segment registers on I/O
//  FCh-FFh). Sits between the T80 bus, the PPI port A output and the RAM/ROM/cart
//  selects; produces slot selects and the physical RAM address.
// PARAMETERS
//  EXPANDED     4'b1000  bit n=1: primary slot n is expanded (has FFFFh sub-slot reg)
//  SEG_BITS     3        mapper segment register width; RAM = 2^SEG_BITS x 16 KB
//  MAP_SLOT     3        primary slot holding mapper RAM
//  MAP_SUBSLOT  0        sub-slot holding mapper RAM (ignored if MAP_SLOT not expanded)
// PORTS
//  clk_i        in   1          system clock
//  reset_n_i    in   1          asynchronous, active-low reset
//  addr_i       in   16         CPU address
//  d_i          in   8          CPU write data
//  d_o          out  8          read data for intercepted cycles (FFFFh, I/O FCh-FFh)
//  d_oe_o       out  1          1 = d_o must be muxed to CPU this cycle
//  mreq_n_i     in   1          CPU MREQ_n
//  iorq_n_i     in   1          CPU IORQ_n
//  rd_n_i       in   1          CPU RD_n
//  wr_n_i       in   1          CPU WR_n
//  m1_n_i       in   1          CPU M1_n (IORQ with M1 low = INTA, ignored)
//  rfsh_n_i     in   1          CPU RFSH_n
//  prim_sel_i   in   8          PPI port A: 2 bits per page, page p = [2p+1:2p]
//  sltsl_n_o    out  4          primary slot selects, active low
//  subsl_n_o    out  16         sub-slot selects, [4n+m] = slot n.m, active low
//  ram_cs_n_o   out  1          mapper RAM select, active low
//  ram_a_o      out  SEG_BITS+14  physical mapper RAM address {segment, addr_i[13:0]}
// BEHAVIOUR
//  Decode (combinational from registers and bus):
//  - page p = addr_i[15:14]; prim = prim_sel_i[2p+1:2p].
//  - mem = ~mreq_n_i & rfsh_n_i; sltsl_n_o[prim] = ~mem, others 1.
//  - If EXPANDED[prim]: sub = subreg[prim][2p+1:2p]; subsl_n_o[4*prim+sub] low when
//    mem, except FFFFh accesses (register intercept, all subsl_n_o of prim high).
//    Non-expanded slots: their 4 subsl_n_o bits stay 1.
//  - ram_cs_n_o low when mem and slot matches MAP_SLOT (and MAP_SUBSLOT if expanded),
//    not during an intercepted FFFFh access. ram_a_o = {seg[p], addr_i[13:0]}.
//  Registers (all updated on clk_i, write strobe = wr_n_i falling edge, detected as
//  wr_n_q & ~wr_n_i with wr_n_q registered; exactly one update per CPU write):
//  - subreg[n] (8b, only for EXPANDED[n]): written when ~mreq_n_i, addr_i==FFFFh,
//    page-3 primary == n. Read of FFFFh in that case: d_o=~subreg[n], d_oe_o=1.
//    FFFFh with page-3 primary not expanded: no intercept, normal slot select.
//  - seg[0..3] (SEG_BITS): written on ~iorq_n_i & m1_n_i & addr_i[7:0]==FCh+p;
//    stores d_i[SEG_BITS-1:0] (higher bits dropped = wrap modulo RAM size).
//    Read: d_o = {(8-SEG_BITS){1'b1}, seg[p]}, d_oe_o=1.
//  - d_oe_o only while rd_n_i low in the qualifying cycle; otherwise d_o=FFh.
//  Reset (async, reset_n_i low): subreg[*]=00h; seg[0]=3, seg[1]=2, seg[2]=1,
//  seg[3]=0 (mod 2^SEG_BITS); wr_n_q=1; outputs: sltsl_n_o=Fh, subsl_n_o=FFFFh,
//  ram_cs_n_o=1, d_oe_o=0, d_o=FFh (bus idle). Reset mid-write discards the write.
//  - Refresh cycles (rfsh_n_i low): no selects asserted, no register write.
//  - A write to FFFFh takes effect for the next bus cycle; the in-flight cycle
//    decodes with the old value. Write held low many clocks updates once.
//  - Latency: selects/d_o combinational (0 cycles); registers visible 1 clk after strobe.
// TESTING
//  1 Reset, prim_sel=00h, read 0000h -> sltsl_n_o=1110b, subsl_n_o=FFFFh, d_oe_o=0.
//  2 EXPANDED=1000b, prim_sel=C0h, write FFFFh=E4h, read FFFFh -> d_o=1Bh, d_oe_o=1;
//    read C000h -> subsl_n_o[15]=0 (slot 3.3); read 0000h with prim_sel=03h -> 3.0.
//  3 OUT FEh,0Bh (SEG_BITS=3), read 8000h in slot 3.0 -> ram_a_o=0C000h, ram_cs_n_o=0;
//    IN FEh -> d_o=FBh.
//  4 After reset IN FCh..FFh -> 03h,02h,01h,00h with top bits 1 (FBh,FAh,F9h,F8h).
//  5 Refresh cycle at 4000h with mreq_n low, rfsh_n low -> all selects high, no update.
//  6 Assert reset_n_i low during WR_n low on FFFFh -> subreg stays 00h after release.

Source files
------------

// File: rtl/msx_slot_mapper.sv
// MSX slot/memory mapper: primary slot decode, FFFFh sub-slot expanders and
// an MSX2-style RAM mapper with segment registers on I/O FCh-FFh.
module msx_slot_mapper #(
   parameter logic [3:0]  EXPANDED    = 4'b1000,
   parameter int unsigned SEG_BITS    = 3,
   parameter int unsigned MAP_SLOT    = 3,
   parameter int unsigned MAP_SUBSLOT = 0
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic [15:0]           addr_i,
   input  logic [7:0]            d_i,
   output logic [7:0]            d_o,
   output logic                  d_oe_o,
   input  logic                  mreq_n_i,
   input  logic                  iorq_n_i,
   input  logic                  rd_n_i,
   input  logic                  wr_n_i,
   input  logic                  m1_n_i,
   input  logic                  rfsh_n_i,
   input  logic [7:0]            prim_sel_i,
   output logic [3:0]            sltsl_n_o,
   output logic [15:0]           subsl_n_o,
   output logic                  ram_cs_n_o,
   output logic [SEG_BITS+13:0]  ram_a_o
);

   localparam logic [1:0] MAP_SLOT_L    = 2'(MAP_SLOT);
   localparam logic [1:0] MAP_SUBSLOT_L = 2'(MAP_SUBSLOT);

   logic [7:0]          subreg_q [4];
   logic [7:0]          subreg_d [4];
   logic [SEG_BITS-1:0] seg_q [4];
   logic [SEG_BITS-1:0] seg_d [4];
   logic                wr_n_q, wr_n_d;

   logic [1:0] page, prim, sub;
   logic       mem, ffff_hit, io_hit, wr_stb;
   logic [7:0] seg_rd;

   always_comb begin
      page     = addr_i[15:14];
      prim     = prim_sel_i[{page, 1'b0} +: 2];
      sub      = subreg_q[prim][{page, 1'b0} +: 2];
      mem      = ~mreq_n_i & rfsh_n_i;
      // FFFFh is only intercepted when the page-3 slot actually has an expander
      ffff_hit = mem & (addr_i == 16'hFFFF) & EXPANDED[prim];
      io_hit   = ~iorq_n_i & m1_n_i & (addr_i[7:2] == 6'h3F);
      wr_stb   = wr_n_q & ~wr_n_i;
   end

   always_comb begin
      subreg_d = subreg_q;
      seg_d    = seg_q;
      wr_n_d   = wr_n_i;
      if (wr_stb && ffff_hit)
         subreg_d[prim] = d_i;
      if (wr_stb && io_hit)
         seg_d[addr_i[1:0]] = d_i[SEG_BITS-1:0];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_n_q <= 1'b1;
         for (int unsigned i = 0; i < 4; i++) begin
            subreg_q[i] <= '0;
            seg_q[i]    <= SEG_BITS'(3 - i);
         end
      end else begin
         wr_n_q   <= wr_n_d;
         subreg_q <= subreg_d;
         seg_q    <= seg_d;
      end
   end

   always_comb begin
      sltsl_n_o = '1;
      subsl_n_o = '1;
      if (mem)
         sltsl_n_o[prim] = 1'b0;
      if (mem && EXPANDED[prim] && !ffff_hit)
         subsl_n_o[{prim, sub}] = 1'b0;

      ram_cs_n_o = ~(mem && !ffff_hit && (prim == MAP_SLOT_L) &&
                     (!EXPANDED[MAP_SLOT_L] || (sub == MAP_SUBSLOT_L)));
      ram_a_o    = {seg_q[page], addr_i[13:0]};

      seg_rd = '1;
      seg_rd[SEG_BITS-1:0] = seg_q[addr_i[1:0]];

      d_o    = 8'hFF;
      d_oe_o = 1'b0;
      if (!rd_n_i) begin
         if (ffff_hit) begin
            d_o    = ~subreg_q[prim];
            d_oe_o = 1'b1;
         end else if (io_hit) begin
            d_o    = seg_rd;
            d_oe_o = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_msx_slot_mapper.sv
// Directed bench for msx_slot_mapper: stimulus pushes expected bus-side
// outputs into a queue, a monitor pops and compares on each sample strobe.
module tb_msx_slot_mapper;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  d_in = '0;
   logic [7:0]  d_out;
   logic        d_oe;
   logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
   logic        m1_n = 1'b1, rfsh_n = 1'b1;
   logic [7:0]  prim_sel = '0;
   logic [3:0]  sltsl_n;
   logic [15:0] subsl_n;
   logic        ram_cs_n;
   logic [16:0] ram_a;

   always #5 clk = ~clk;

   msx_slot_mapper #(
      .EXPANDED(4'b1000), .SEG_BITS(3), .MAP_SLOT(3), .MAP_SUBSLOT(0)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr), .d_i(d_in),
      .d_o(d_out), .d_oe_o(d_oe), .mreq_n_i(mreq_n), .iorq_n_i(iorq_n),
      .rd_n_i(rd_n), .wr_n_i(wr_n), .m1_n_i(m1_n), .rfsh_n_i(rfsh_n),
      .prim_sel_i(prim_sel), .sltsl_n_o(sltsl_n), .subsl_n_o(subsl_n),
      .ram_cs_n_o(ram_cs_n), .ram_a_o(ram_a)
   );

   typedef struct {
      string       name;
      logic [3:0]  sl;
      logic [15:0] sub;
      logic        cs;
      logic [16:0] ra;
      logic [7:0]  d;
      logic        oe;
   } exp_t;

   exp_t exp_q[$];
   logic sample_tick = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge sample_tick) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_sample: no expected entry queued");
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (sltsl_n !== e.sl || subsl_n !== e.sub || ram_cs_n !== e.cs ||
             ram_a !== e.ra || d_out !== e.d || d_oe !== e.oe) begin
            errors++;
            $display("FAIL %s: got sl=%b sub=%h cs=%b ra=%h d=%h oe=%b, want sl=%b sub=%h cs=%b ra=%h d=%h oe=%b",
                     e.name, sltsl_n, subsl_n, ram_cs_n, ram_a, d_out, d_oe,
                     e.sl, e.sub, e.cs, e.ra, e.d, e.oe);
         end
      end
   end

   task automatic expect_now(input string name, input logic [3:0] sl,
                             input logic [15:0] sub, input logic cs,
                             input logic [16:0] ra, input logic [7:0] d,
                             input logic oe);
      exp_t e;
      e.name = name; e.sl = sl; e.sub = sub; e.cs = cs;
      e.ra = ra; e.d = d; e.oe = oe;
      #2;
      exp_q.push_back(e);
      sample_tick = 1'b1;
      #1 sample_tick = 1'b0;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      m1_n = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic mem_rd(input logic [15:0] a, input string name,
                         input logic [3:0] sl, input logic [15:0] sub,
                         input logic cs, input logic [16:0] ra,
                         input logic [7:0] d, input logic oe);
      @(negedge clk);
      addr = a; mreq_n = 1'b0; rd_n = 1'b0;
      expect_now(name, sl, sub, cs, ra, d, oe);
      bus_idle();
   endtask

   task automatic io_rd(input logic [7:0] port, input string name,
                        input logic [7:0] d, input logic [16:0] ra);
      @(negedge clk);
      addr = {8'h00, port}; iorq_n = 1'b0; rd_n = 1'b0;
      expect_now(name, 4'hF, 16'hFFFF, 1'b1, ra, d, 1'b1);
      bus_idle();
   endtask

   // Data changes to d_late mid-write; only the value at the falling edge may land.
   task automatic mem_wr(input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] d_late, input int unsigned hold);
      @(negedge clk);
      addr = a; d_in = d; mreq_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      d_in = d_late;
      repeat (hold) @(negedge clk);
      bus_idle();
   endtask

   task automatic io_wr(input logic [7:0] port, input logic [7:0] d);
      @(negedge clk);
      addr = {8'h00, port}; d_in = d; iorq_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      bus_idle();
   endtask

   initial begin
      // reset state with idle bus
      @(negedge clk);
      expect_now("reset_idle", 4'hF, 16'hFFFF, 1'b1, 17'h0C000, 8'hFF, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      prim_sel = 8'h00;
      mem_rd(16'h0000, "rd0000_slot0", 4'b1110, 16'hFFFF, 1'b1, 17'h0C000, 8'hFF, 1'b0);

      io_rd(8'hFC, "in_fc_reset", 8'hFB, 17'h0C0FC);
      io_rd(8'hFD, "in_fd_reset", 8'hFA, 17'h0C0FD);
      io_rd(8'hFE, "in_fe_reset", 8'hF9, 17'h0C0FE);
      io_rd(8'hFF, "in_ff_reset", 8'hF8, 17'h0C0FF);

      // FFFFh with page-3 slot 0 (not expanded): no intercept
      mem_rd(16'hFFFF, "ffff_not_expanded", 4'b1110, 16'hFFFF, 1'b1, 17'h03FFF, 8'hFF, 1'b0);

      prim_sel = 8'hC0;
      mem_rd(16'hFFFF, "ffff_reset_val", 4'b0111, 16'hFFFF, 1'b1, 17'h03FFF, 8'hFF, 1'b1);
      mem_wr(16'hFFFF, 8'hE4, 8'hE4, 1);
      mem_rd(16'hFFFF, "ffff_inverted", 4'b0111, 16'hFFFF, 1'b1, 17'h03FFF, 8'h1B, 1'b1);
      mem_rd(16'hC000, "slot3_3_page3", 4'b0111, 16'h7FFF, 1'b1, 17'h00000, 8'hFF, 1'b0);
      prim_sel = 8'h03;
      mem_rd(16'h0000, "slot3_0_page0", 4'b0111, 16'hEFFF, 1'b0, 17'h0C000, 8'hFF, 1'b0);

      // OUT FEh,0Bh wraps to segment 3
      io_wr(8'hFE, 8'h0B);
      prim_sel = 8'hF0;
      mem_wr(16'hFFFF, 8'hC4, 8'h00, 4);
      mem_rd(16'hFFFF, "long_write_once", 4'b0111, 16'hFFFF, 1'b1, 17'h03FFF, 8'h3B, 1'b1);
      mem_rd(16'h8000, "map_ram_seg3", 4'b0111, 16'hEFFF, 1'b0, 17'h0C000, 8'hFF, 1'b0);
      io_rd(8'hFE, "in_fe_written", 8'hFB, 17'h0C0FE);

      // refresh cycle: no selects, and a write strobe under it must not land
      @(negedge clk);
      addr = 16'h4000; mreq_n = 1'b0; rfsh_n = 1'b0;
      expect_now("refresh_4000", 4'hF, 16'hFFFF, 1'b1, 17'h08000, 8'hFF, 1'b0);
      bus_idle();
      @(negedge clk);
      addr = 16'hFFFF; d_in = 8'h00; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      bus_idle();
      mem_rd(16'hFFFF, "refresh_no_write", 4'b0111, 16'hFFFF, 1'b1, 17'h03FFF, 8'h3B, 1'b1);

      // reset asserted mid-write: write discarded, registers back to defaults
      @(negedge clk);
      addr = 16'hFFFF; d_in = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      mreq_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      mem_rd(16'hFFFF, "reset_mid_write", 4'b0111, 16'hFFFF, 1'b1, 17'h03FFF, 8'hFF, 1'b1);
      io_rd(8'hFE, "seg_after_reset", 8'hF9, 17'h0C0FE);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
